ess_detector: RTL and testbench

- Emergency Stop Signal detector. Sits directly upstream of the turn-signal block and drives its `ess_active` input.
- Samples vehicle speed at a fixed rate and computes per-sample deceleration.
- Asserts `ess_active` on confirmed hard braking from high speed.
- Holds `ess_active` through the stop, then releases on accelerator press, restart of motion, or hold timeout.

---
 rtl/car_pkg.sv | 15 +
 rtl/sample_tick_gen.sv | 28 ++
 rtl/ess_detector.sv | 133 +++++++++++++
 tb/tb_ess_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared vehicle-domain types and constants for the body-control blocks.
// Holds the ESS state encoding and the clock/speed defaults.
package car_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } ess_state_t;

  localparam int SPEED_W_DEF = 8;
  localparam int CLK_HZ      = 50_000_000;
  localparam int SAMPLE_HZ   = 10;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: one-cycle tick every N clocks, counter cleared by rst.
// Shared by the ESS detector, the speed model and the display refresh.
module sample_tick_gen #(
  parameter int N = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == CW'(N - 1));

  // Modulo-N sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (tick) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/ess_detector.sv
// Emergency Stop Signal detector: flags confirmed hard braking from speed and
// holds the request through standstill until accel, restart or timeout.
module ess_detector
  import car_pkg::*;
#(
  parameter int SAMPLE_TICKS = CLK_HZ / SAMPLE_HZ,
  parameter int SPEED_W      = SPEED_W_DEF,
  parameter int MIN_SPEED    = 55,
  parameter int DECEL_TH     = 7,
  parameter int CONFIRM      = 2,
  parameter int HOLD_SAMPLES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] speed,
  input  logic               brake,
  input  logic               accel,
  output logic               ess_active,
  output logic [SPEED_W-1:0] decel
);

  localparam int CCW = $clog2(CONFIRM + 1);
  localparam int HCW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

  ess_state_t         state_r;
  ess_state_t         state_nx_s;
  logic [SPEED_W-1:0] prev_speed_r;
  logic [SPEED_W-1:0] d_s;
  logic               hit_s;
  logic               tick_s;
  logic [CCW-1:0]     confirm_cnt_r;
  logic [HCW-1:0]     hold_cnt_r;
  logic [HCW-1:0]     hold_nx_s;

  sample_tick_gen #(.N(SAMPLE_TICKS)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // Saturating per-sample drop and hit qualification against pre-update speed
  always_comb begin
    d_s = {SPEED_W{1'b0}};
    if (prev_speed_r > speed) begin
      d_s = prev_speed_r - speed;
    end else begin
      d_s = {SPEED_W{1'b0}};
    end
    hit_s = brake && (prev_speed_r >= SPEED_W'(MIN_SPEED)) && (d_s >= SPEED_W'(DECEL_TH));
  end

  // Next-state and hold-counter logic; accel outranks every tick-driven move
  always_comb begin
    state_nx_s = state_r;
    hold_nx_s  = hold_cnt_r;
    case (state_r)
      IDLE: begin
        hold_nx_s = {HCW{1'b0}};
        if (!accel && tick_s && hit_s && (confirm_cnt_r == CCW'(CONFIRM - 1))) begin
          state_nx_s = ACTIVE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACTIVE: begin
        if (accel) begin
          state_nx_s = IDLE;
        end else if (tick_s && (speed == {SPEED_W{1'b0}})) begin
          state_nx_s = HOLD;
          hold_nx_s  = {HCW{1'b0}};
        end else begin
          state_nx_s = ACTIVE;
        end
      end
      HOLD: begin
        if (accel) begin
          state_nx_s = IDLE;
        end else if (tick_s) begin
          if (speed != {SPEED_W{1'b0}}) begin
            state_nx_s = IDLE;
          end else if (hold_cnt_r == HCW'(HOLD_SAMPLES - 1)) begin
            state_nx_s = IDLE;
          end else begin
            hold_nx_s = hold_cnt_r + HCW'(1);
          end
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: begin
        state_nx_s = IDLE;
        hold_nx_s  = {HCW{1'b0}};
      end
    endcase
  end

  // State, registered outputs and speed history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      ess_active   <= 1'b0;
      decel        <= {SPEED_W{1'b0}};
      prev_speed_r <= {SPEED_W{1'b0}};
      hold_cnt_r   <= {HCW{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      ess_active <= (state_nx_s != IDLE);
      hold_cnt_r <= hold_nx_s;
      if (tick_s) begin
        decel        <= d_s;
        prev_speed_r <= speed;
      end
    end
  end

  // Consecutive-hit counter, only live while idle with accel released
  always_ff @(posedge clk) begin
    if (rst) begin
      confirm_cnt_r <= {CCW{1'b0}};
    end else if ((state_r != IDLE) || accel) begin
      confirm_cnt_r <= {CCW{1'b0}};
    end else if (tick_s) begin
      if (!hit_s) begin
        confirm_cnt_r <= {CCW{1'b0}};
      end else if (confirm_cnt_r == CCW'(CONFIRM)) begin
        confirm_cnt_r <= confirm_cnt_r;
      end else begin
        confirm_cnt_r <= confirm_cnt_r + CCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ess_detector.sv
// Directed bench for ess_detector with a 10-cycle sample period; every
// stimulus step ends just after a tick edge so outputs can be compared there.
`timescale 1ns/1ps
module tb_ess_detector;

  localparam int ST = 10;

  logic       clk;
  logic       rst;
  logic [7:0] speed;
  logic       brake;
  logic       accel;
  logic       ess_active;
  logic [7:0] decel;

  int checks_r;
  int failures_r;

  ess_detector #(
    .SAMPLE_TICKS (ST),
    .SPEED_W      (8),
    .MIN_SPEED    (55),
    .DECEL_TH     (7),
    .CONFIRM      (2),
    .HOLD_SAMPLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .speed      (speed),
    .brake      (brake),
    .accel      (accel),
    .ess_active (ess_active),
    .decel      (decel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold one speed for a full sample period; returns just after the tick edge.
  task automatic sample(input logic [7:0] spd);
    speed = spd;
    cycles(ST);
  endtask

  task automatic apply_reset();
    brake = 1'b0;
    accel = 1'b0;
    speed = 8'd0;
    rst   = 1'b1;
    cycles(1);
    rst   = 1'b0;
  endtask

  task automatic trigger();
    brake = 1'b1;
    sample(8'd80);
    sample(8'd72);
    sample(8'd64);
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    speed      = 8'd0;
    brake      = 1'b0;
    accel      = 1'b0;
    checks_r   = 0;
    failures_r = 0;

    apply_reset();
    check_eq("rst_ess", 32'(ess_active), 32'd0);
    check_eq("rst_decel", 32'(decel), 32'd0);

    // 1: hard brake 80->72->64->56
    brake = 1'b1;
    sample(8'd80);
    check_eq("t1_decel_tick1", 32'(decel), 32'd0);
    check_eq("t1_ess_tick1", 32'(ess_active), 32'd0);
    sample(8'd72);
    check_eq("t1_decel_tick2", 32'(decel), 32'd8);
    check_eq("t1_ess_tick2", 32'(ess_active), 32'd0);
    sample(8'd64);
    check_eq("t1_decel_tick3", 32'(decel), 32'd8);
    check_eq("t1_ess_tick3", 32'(ess_active), 32'd1);
    sample(8'd56);
    check_eq("t1_ess_tick4", 32'(ess_active), 32'd1);
    brake = 1'b0;
    sample(8'd50);
    check_eq("t1_ess_brake_rel", 32'(ess_active), 32'd1);

    // 3: stop and hold for 4 further ticks
    sample(8'd0);
    check_eq("t3_ess_enter_hold", 32'(ess_active), 32'd1);
    check_eq("t3_decel_stop", 32'(decel), 32'd50);
    for (int i = 0; i < 3; i++) begin
      sample(8'd0);
      check_eq($sformatf("t3_ess_hold%0d", i + 1), 32'(ess_active), 32'd1);
    end
    cycles(ST - 1);
    check_eq("t3_ess_before_4th", 32'(ess_active), 32'd1);
    cycles(1);
    check_eq("t3_ess_after_4th", 32'(ess_active), 32'd0);

    // 2A: drops of 8 starting below MIN_SPEED
    apply_reset();
    brake = 1'b1;
    sample(8'd50);
    sample(8'd42);
    check_eq("t2a_decel", 32'(decel), 32'd8);
    sample(8'd34);
    sample(8'd26);
    check_eq("t2a_ess", 32'(ess_active), 32'd0);

    // 2B: drops of 6 are below threshold
    apply_reset();
    brake = 1'b1;
    sample(8'd90);
    sample(8'd84);
    sample(8'd78);
    check_eq("t2b_decel", 32'(decel), 32'd6);
    sample(8'd72);
    check_eq("t2b_ess", 32'(ess_active), 32'd0);

    // 2C: no brake
    apply_reset();
    brake = 1'b0;
    sample(8'd80);
    sample(8'd72);
    sample(8'd64);
    sample(8'd56);
    check_eq("t2c_ess", 32'(ess_active), 32'd0);

    // Boundary: prev exactly 55 and drop exactly 7 still trigger
    apply_reset();
    brake = 1'b1;
    sample(8'd62);
    sample(8'd55);
    check_eq("bnd_ess_first_hit", 32'(ess_active), 32'd0);
    sample(8'd48);
    check_eq("bnd_decel", 32'(decel), 32'd7);
    check_eq("bnd_ess", 32'(ess_active), 32'd1);

    // 4a: accel between ticks in HOLD
    apply_reset();
    trigger();
    sample(8'd0);
    check_eq("t4a_ess_hold", 32'(ess_active), 32'd1);
    cycles(3);
    accel = 1'b1;
    cycles(1);
    check_eq("t4a_ess_accel", 32'(ess_active), 32'd0);
    accel = 1'b0;
    cycles(ST - 4);

    // 4b: motion restarts at a tick in HOLD
    apply_reset();
    trigger();
    sample(8'd0);
    sample(8'd5);
    check_eq("t4b_ess_restart", 32'(ess_active), 32'd0);
    check_eq("t4b_decel_rise", 32'(decel), 32'd0);

    // 5: reset mid-ACTIVE, then fresh confirmation
    apply_reset();
    trigger();
    check_eq("t5_ess_active", 32'(ess_active), 32'd1);
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_eq("t5_ess_after_rst", 32'(ess_active), 32'd0);
    check_eq("t5_decel_after_rst", 32'(decel), 32'd0);
    sample(8'd80);
    check_eq("t5_decel_first", 32'(decel), 32'd0);
    sample(8'd72);
    check_eq("t5_ess_one_hit", 32'(ess_active), 32'd0);
    sample(8'd64);
    check_eq("t5_ess_retrig", 32'(ess_active), 32'd1);

    // 6: non-hit between hits resets confirmation
    apply_reset();
    brake = 1'b1;
    sample(8'd100);
    sample(8'd92);
    sample(8'd90);
    check_eq("t6_decel_small", 32'(decel), 32'd2);
    sample(8'd82);
    check_eq("t6_ess_no_trig", 32'(ess_active), 32'd0);
    sample(8'd74);
    check_eq("t6_ess_trig", 32'(ess_active), 32'd1);

    // Max speed and upward jump: saturating difference
    apply_reset();
    brake = 1'b1;
    sample(8'd100);
    sample(8'd255);
    check_eq("max_decel_jump", 32'(decel), 32'd0);
    sample(8'd0);
    check_eq("max_decel_full", 32'(decel), 32'd255);
    check_eq("max_ess", 32'(ess_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
